// File: rtl/uart_rx_frame_if.sv
// uart_rx_frame_if: serial line in, received byte stream out.
// Ports: rx (serial line, idles high), rx_data (last good byte),
// rx_valid (one-cycle new-byte strobe), frame_err (one-cycle bad-stop strobe),
// busy (receiver mid-frame). master = receiver side, slave = line driver / byte sink.
interface uart_rx_frame_if;
   logic       rx;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       busy;
   modport master (input rx, output rx_data, output rx_valid, output frame_err, output busy);
   modport slave (output rx, input rx_data, input rx_valid, input frame_err, input busy);
endinterface

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: 8N1 UART receiver with false-start rejection and stop-bit check.
// Ports: clk (system clock), rst_n (async active-low reset),
// bus (uart_rx_frame_if.master: rx in; rx_data, rx_valid, frame_err, busy out).
module uart_rx_frame #(
   parameter int CLK_FREQ = 50_000_000,
   parameter int BAUD     = 9600
) (
   input logic            clk,
   input logic            rst_n,
   uart_rx_frame_if.master bus
);
   localparam int BIT_MAX = CLK_FREQ / BAUD;
   localparam int HALF    = BIT_MAX / 2;
   localparam int CW      = $clog2(BIT_MAX);
   localparam logic [CW-1:0] C_END = CW'(BIT_MAX - 1);
   localparam logic [CW-1:0] C_MID = CW'(HALF);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;
   logic [2:0]    sync;
   logic          rx_s, rx_d, fall, mid, last;
   logic [1:0]    state, state_nx;
   logic [CW-1:0] cnt;
   logic [2:0]    idx;
   logic [7:0]    shreg;
   assign rx_s     = sync[1];
   assign rx_d     = sync[2];
   assign fall     = rx_d & ~rx_s;
   assign mid      = cnt == C_MID;
   assign last     = cnt == C_END;
   assign bus.busy = state != IDLE;
   // Leaving STOP at mid-bit lets a back-to-back start edge be caught.
   always_comb
      state_nx = state == IDLE  ? (fall ? START : IDLE) :
                 state == START ? ((mid && rx_s) ? IDLE : last ? DATA : START) :
                 state == DATA  ? ((last && idx == 3'd7) ? STOP : DATA) :
                 (mid ? IDLE : STOP);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync          <= 3'b111;
         state         <= IDLE;
         cnt           <= '0;
         idx           <= '0;
         shreg         <= '0;
         bus.rx_data   <= '0;
         bus.rx_valid  <= 1'b0;
         bus.frame_err <= 1'b0;
      end else begin
         sync          <= {sync[1:0], bus.rx};
         state         <= state_nx;
         cnt           <= (state == IDLE || state_nx != state || last) ? '0 : cnt + 1'b1;
         bus.rx_valid  <= 1'b0;
         bus.frame_err <= 1'b0;
         if (state == START && last) idx <= '0;
         if (state == DATA && mid) shreg <= {rx_s, shreg[7:1]};
         if (state == DATA && last && idx != 3'd7) idx <= idx + 1'b1;
         if (state == STOP && mid) begin
            if (rx_s) begin
               bus.rx_data  <= shreg;
               bus.rx_valid <= 1'b1;
            end else begin
               bus.frame_err <= 1'b1;
            end
         end
      end
   end
endmodule
